// File: rtl/regfile_mmio.sv
// regfile_mmio: general-purpose register file with two combinational read
// ports, one synchronous write port, optional same-cycle write forwarding,
// and two hardwired memory-mapped registers (sticky W1C keypad, timer).
module regfile_mmio #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 32,
   parameter int ADDR_W    = 5,
   parameter int KEY_W     = 20,
   parameter int KEY_REG   = 29,
   parameter int TIMER_REG = 31,
   parameter bit BYPASS    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] AdrReg1,
   input  logic [ADDR_W-1:0] AdrReg2,
   input  logic [ADDR_W-1:0] AdrRegd,
   input  logic [WIDTH-1:0]  regWriteData,
   input  logic [KEY_W-1:0]  interrupt,
   input  logic [WIDTH-1:0]  MilliSeconds,
   output logic [WIDTH-1:0]  ReadData1,
   output logic [WIDTH-1:0]  ReadData2,
   output logic              KeyPending
);

   // Entries 0, KEY_REG and TIMER_REG are never written and stay zero;
   // their reads are served by dedicated logic below.
   logic [WIDTH-1:0] regs [DEPTH];
   logic [KEY_W-1:0] interruptQ;
   logic [KEY_W-1:0] keySticky;
   logic [KEY_W-1:0] keyRise;
   logic [KEY_W-1:0] keyClr;
   logic [WIDTH-1:0] keyExt;
   logic [WIDTH-1:0] timerQ;
   logic             writeGeneral;

   // True for in-range addresses that are neither r0 nor a hardwired register.
   function automatic logic isGeneral(input logic [ADDR_W-1:0] a);
      return (32'(a) < DEPTH) && (a != '0) &&
             (a != ADDR_W'(KEY_REG)) && (a != ADDR_W'(TIMER_REG));
   endfunction

   // Combinational read of one port: array/keypad/timer decode plus forwarding.
   function automatic logic [WIDTH-1:0] readPort(input logic [ADDR_W-1:0] a);
      logic [WIDTH-1:0] rd;
      rd = '0;
      if (a == ADDR_W'(KEY_REG)) begin
         rd = keyExt;
      end else if (a == ADDR_W'(TIMER_REG)) begin
         rd = timerQ;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (a == ADDR_W'(i)) rd = regs[i];
         end
      end
      // Forwarding is suppressed during reset, where the write is discarded.
      if (BYPASS && !reset && writeGeneral && (AdrRegd == a)) rd = regWriteData;
      return rd;
   endfunction

   // Write qualification and keypad edge/clear terms.
   always_comb begin
      writeGeneral = RegWrite && isGeneral(AdrRegd);
      keyRise      = interrupt & ~interruptQ;
      keyClr       = '0;
      if (RegWrite && (AdrRegd == ADDR_W'(KEY_REG))) keyClr = regWriteData[KEY_W-1:0];
      keyExt                = '0;
      keyExt[KEY_W-1:0]     = keySticky;
   end

   // General register array: reset clears, one qualified write per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (writeGeneral && (AdrRegd == ADDR_W'(i))) regs[i] <= regWriteData;
         end
      end
   end

   // Keypad sticky bits (set beats clear) and timer snapshot; interruptQ
   // tracks the input through reset so held keys do not fire on release.
   always_ff @(posedge clk) begin
      interruptQ <= interrupt;
      if (reset) begin
         keySticky <= '0;
         timerQ    <= '0;
      end else begin
         keySticky <= (keySticky & ~keyClr) | keyRise;
         timerQ    <= MilliSeconds;
      end
   end

   // Output decode.
   always_comb begin
      ReadData1  = readPort(AdrReg1);
      ReadData2  = readPort(AdrReg2);
      KeyPending = |keySticky;
   end

endmodule

// File: tb/tb_regfile_mmio.sv
// Directed bench for regfile_mmio: one forwarding instance with default
// parameters and one non-forwarding, reduced-depth instance.
module tb_regfile_mmio;

   logic        clk;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  AdrReg1;
   logic [4:0]  AdrReg2;
   logic [4:0]  AdrRegd;
   logic [31:0] regWriteData;
   logic [19:0] interrupt;
   logic [31:0] MilliSeconds;
   logic [31:0] rdA1, rdA2, rdB1, rdB2;
   logic        pendA, pendB;

   int checks = 0;
   int errors = 0;

   // Default parameters, forwarding enabled.
   regfile_mmio uA (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .AdrReg1(AdrReg1), .AdrReg2(AdrReg2), .AdrRegd(AdrRegd),
      .regWriteData(regWriteData), .interrupt(interrupt),
      .MilliSeconds(MilliSeconds),
      .ReadData1(rdA1), .ReadData2(rdA2), .KeyPending(pendA)
   );

   // No forwarding, 24 registers so addresses 24..31 are out of range.
   regfile_mmio #(.DEPTH(24), .KEY_REG(20), .TIMER_REG(21), .BYPASS(1'b0)) uB (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .AdrReg1(AdrReg1), .AdrReg2(AdrReg2), .AdrRegd(AdrRegd),
      .regWriteData(regWriteData), .interrupt(interrupt),
      .MilliSeconds(MilliSeconds),
      .ReadData1(rdB1), .ReadData2(rdB2), .KeyPending(pendB)
   );

   // Clock block.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      RegWrite = 1'b1;
      AdrRegd = a;
      regWriteData = d;
   endtask

   initial begin
      reset = 1'b1; RegWrite = 1'b0; AdrReg1 = '0; AdrReg2 = '0; AdrRegd = '0;
      regWriteData = '0; interrupt = '0; MilliSeconds = '0;
      tick(); tick();
      reset = 1'b0;
      AdrReg1 = 5'd5; AdrReg2 = 5'd29; #1;
      check("reset_r5", rdA1, 32'h0);
      check("reset_key", rdA2, 32'h0);
      check("reset_pending", {31'b0, pendA}, 32'h0);
      AdrReg2 = 5'd31; #1;
      check("reset_timer", rdA2, 32'h0);

      // Plain write, visible next cycle.
      write(5'd5, 32'hDEADBEEF); tick(); RegWrite = 1'b0;
      AdrReg1 = 5'd5; #1;
      check("r5_A", rdA1, 32'hDEADBEEF);
      check("r5_B", rdB1, 32'hDEADBEEF);

      // r0 is hardwired to zero.
      write(5'd0, 32'h1234); tick(); RegWrite = 1'b0;
      AdrReg2 = 5'd0; #1;
      check("r0_A", rdA2, 32'h0);

      // Same-cycle forwarding versus none.
      write(5'd7, 32'hA5A5A5A5); AdrReg1 = 5'd7; AdrReg2 = 5'd7; #1;
      check("byp_A1", rdA1, 32'hA5A5A5A5);
      check("byp_A2", rdA2, 32'hA5A5A5A5);
      check("nobyp_B1", rdB1, 32'h0);
      tick(); RegWrite = 1'b0; #1;
      check("r7_A", rdA1, 32'hA5A5A5A5);
      check("r7_B", rdB1, 32'hA5A5A5A5);

      // Address 25: general in A, out of range in B.
      write(5'd25, 32'h0BADF00D); tick(); RegWrite = 1'b0;
      AdrReg1 = 5'd25; #1;
      check("r25_A", rdA1, 32'h0BADF00D);
      check("oor_B", rdB1, 32'h0);

      // Keypad: held key latches once.
      AdrReg1 = 5'd29;
      interrupt = 20'h00008; tick();
      check("key_set", rdA1, 32'h8);
      check("key_pend", {31'b0, pendA}, 32'h1);
      tick(); tick(); tick();
      check("key_held", rdA1, 32'h8);
      // W1C: no forwarding of write data onto KEY_REG.
      write(5'd29, 32'hFFFFFFFF); #1;
      check("key_nobyp", rdA1, 32'h8);
      tick(); RegWrite = 1'b0;
      check("key_clr", rdA1, 32'h0);
      check("key_clr_pend", {31'b0, pendA}, 32'h0);
      tick();
      check("key_held_noset", rdA1, 32'h0);
      interrupt = 20'h0; tick();
      interrupt = 20'h00008; tick();
      check("key_repress", rdA1, 32'h8);

      // Rise and clear of bit 0 in the same cycle: set wins.
      interrupt = 20'h00009; write(5'd29, 32'h1); tick(); RegWrite = 1'b0;
      check("key_setwins", rdA1, 32'h9);
      write(5'd29, 32'h000FFFFF); tick(); RegWrite = 1'b0;
      check("key_clrall", rdA1, 32'h0);
      check("key_clrall_pend", {31'b0, pendA}, 32'h0);

      // Timer snapshot lags input by one edge; writes ignored.
      AdrReg2 = 5'd31;
      MilliSeconds = 32'd1000; tick();
      MilliSeconds = 32'd2000; #1;
      check("timer_1000", rdA2, 32'd1000);
      write(5'd31, 32'h55); #1;
      check("timer_nobyp", rdA2, 32'd1000);
      tick(); RegWrite = 1'b0;
      check("timer_2000", rdA2, 32'd2000);

      // Reset with a key going high and a write to r9 in the same cycle.
      interrupt = 20'h0; tick();
      reset = 1'b1; interrupt = 20'h00001; write(5'd9, 32'h99999999);
      AdrReg1 = 5'd9; AdrReg2 = 5'd5;
      tick();
      check("rst_r9", rdA1, 32'h0);
      check("rst_r5", rdA2, 32'h0);
      reset = 1'b0; RegWrite = 1'b0; tick();
      check("post_r9", rdA1, 32'h0);
      AdrReg1 = 5'd29; #1;
      check("post_key", rdA1, 32'h0);
      check("post_pend", {31'b0, pendA}, 32'h0);
      tick();
      check("post_key2", rdA1, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
